// File: rtl/uart_rx_deframer_if.sv
// Serial receive interface: rx line in, recovered byte and status strobes out.
// master = the deframer, slave = whatever drives the line and consumes the bytes.
interface uart_rx_deframer_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled recovery of 8N1 frames (8E1 with UART_RX_PARITY_EN).
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deframer #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned OVS     = 16
) (
    input  logic                clk_sis,
    input  logic                rst,
    uart_rx_deframer_if.master  bus
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic                r_rx_prev;
    logic [DIV_W-1:0]    r_div;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_data_out;
    logic                r_data_valid;
    logic                r_frame_err;
    logic                r_busy;
`ifdef UART_RX_PARITY_EN
    logic                r_par_bit;
    logic                r_parity_err;
`endif

    logic                w_tick;
    logic                w_rx_fall;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_rx_fall = r_rx_prev & ~r_rx_s;

    // Synchronizer, tick divider and frame FSM with registered outputs.
    always_ff @(posedge clk_sis) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_div        <= '0;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta    <= bus.rx;
            r_rx_s       <= r_rx_meta;
            r_rx_prev    <= r_rx_s;
            r_div        <= w_tick ? '0 : r_div + DIV_W'(1);
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rx_fall) begin
                        r_state    <= ST_START;
                        r_busy     <= 1'b1;
                        r_div      <= '0;
                        r_tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit check rejects short glitches.
                    if (w_tick) begin
                        if (r_tick_cnt == HALF_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            if (r_rx_s) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == BIT_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rx_s, r_shift[7:1]};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        if (r_tick_cnt == BIT_LAST) begin
                            r_tick_cnt <= '0;
                            r_par_bit  <= r_rx_s;
                            r_state    <= ST_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    // Leave mid-stop so a start edge at the end of the stop bit is caught.
                    if (w_tick) begin
                        if (r_tick_cnt == BIT_LAST) begin
                            r_tick_cnt <= '0;
                            if (r_rx_s) begin
                                r_data_out   <= r_shift;
                                r_data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                r_parity_err <= ^{r_shift, r_par_bit};
`endif
                                r_state      <= ST_IDLE;
                                r_busy       <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_WAIT_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low line yields a single framing error.
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = r_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
